// File: rtl/tt_dfd_lane_packer.sv
// tt_dfd_lane_packer: packs 0..NUM_IN valid lanes per beat into dense NUM_OUT-lane words, oldest lane first
//   clk, reset_n          : clock, asynchronous active-low reset
//   data_in/in_count      : input lanes, lanes 0..in_count-1 valid; in_valid/in_ready handshake
//   data_out/out_count    : packed word, lane 0 oldest, lanes >= out_count zero; out_valid/out_ready handshake
//   flush_req/flush_done  : drain request pulse / one-cycle completion pulse with accumulator empty
//   fill_level            : lanes currently held
module tt_dfd_lane_packer #(
  parameter int NUM_IN = 6,
  parameter int NUM_OUT = 8,
  parameter int LANE_WIDTH = 10,
  localparam int CAP = NUM_OUT + NUM_IN,
  localparam int IN_CNT_W = $clog2(NUM_IN + 1),
  localparam int OUT_CNT_W = $clog2(NUM_OUT + 1),
  localparam int FILL_W = $clog2(CAP + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_IN*LANE_WIDTH-1:0]   data_in,
  input  logic [IN_CNT_W-1:0]            in_count,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_OUT*LANE_WIDTH-1:0]  data_out,
  output logic [OUT_CNT_W-1:0]           out_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [FILL_W-1:0]              fill_level
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state, state_nxt;
  logic [FILL_W-1:0] fill;
  logic [CAP-1:0][LANE_WIDTH-1:0] acc, acc_nxt;
  int pop_n, cnt, base, fill_sum;
  assign fill_level = fill;
  assign flush_done = state == DONE;
  // fill <= NUM_OUT leaves room for a full NUM_IN beat even without a pop
  assign in_ready = state == IDLE && fill <= FILL_W'(NUM_OUT);
  assign out_valid = state == IDLE ? fill >= FILL_W'(NUM_OUT) : state == FLUSH && fill != '0;
  assign out_count = state == IDLE ? (out_valid ? OUT_CNT_W'(NUM_OUT) : '0) :
                     state == FLUSH ? (fill < FILL_W'(NUM_OUT) ? OUT_CNT_W'(fill) : OUT_CNT_W'(NUM_OUT)) : '0;
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_OUT; i++)
      data_out[i*LANE_WIDTH +: LANE_WIDTH] = i < int'(out_count) ? acc[i] : '0;
  end
  // pop shifts the accumulator down first; the new beat lands right after the survivors
  always_comb begin
    pop_n = out_valid && out_ready ? int'(out_count) : 0;
    cnt = in_valid && in_ready ? (int'(in_count) > NUM_IN ? NUM_IN : int'(in_count)) : 0;
    base = int'(fill) - pop_n;
    fill_sum = base + cnt;
    for (int i = 0; i < CAP; i++) begin
      acc_nxt[i] = i + pop_n < CAP ? acc[i + pop_n] : '0;
      if (i >= base && i < fill_sum) acc_nxt[i] = data_in[(i - base)*LANE_WIDTH +: LANE_WIDTH];
    end
    state_nxt = state == IDLE ? (flush_req ? FLUSH : IDLE) :
                state == FLUSH ? (fill_sum == 0 ? DONE : FLUSH) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      fill <= '0;
      acc <= '0;
    end else begin
      state <= state_nxt;
      fill <= FILL_W'(fill_sum);
      acc <= acc_nxt;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(in_valid && in_ready && int'(in_count) > NUM_IN)) else $error("in_count %0d exceeds NUM_IN", in_count);
      assert (base >= 0 && fill_sum <= CAP) else $error("fill out of range: %0d", fill_sum);
    end
  end
`endif
endmodule

// File: tb/tb_tt_dfd_lane_packer.sv
// tb_tt_dfd_lane_packer: directed self-checking bench for tt_dfd_lane_packer
module tb_tt_dfd_lane_packer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [59:0] data_in = '0;
  logic [2:0] in_count = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [79:0] data_out;
  logic [3:0] out_count;
  logic out_valid;
  logic out_ready = 1'b0;
  logic flush_req = 1'b0;
  logic flush_done;
  logic [3:0] fill_level;
  int n_assert = 0;
  int n_fail = 0;
  tt_dfd_lane_packer #(.NUM_IN(6), .NUM_OUT(8), .LANE_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .flush_req(flush_req), .flush_done(flush_done), .fill_level(fill_level)
  );
  always #5 clk = ~clk;
  function automatic logic [79:0] w(input int first, input int n);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*10 +: 10] = 10'(first + i);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int n, input int first);
    in_valid = 1'b1;
    in_count = 3'(n);
    data_in = '0;
    for (int i = 0; i < n; i++) data_in[i*10 +: 10] = 10'(first + i);
    step();
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  task automatic chk_idle_empty(input string tag);
    chk({tag, "_in_ready"}, 80'(in_ready), 80'(1));
    chk({tag, "_out_valid"}, 80'(out_valid), 80'(0));
    chk({tag, "_out_count"}, 80'(out_count), 80'(0));
    chk({tag, "_fill"}, 80'(fill_level), 80'(0));
    chk({tag, "_data_out"}, data_out, 80'(0));
    chk({tag, "_flush_done"}, 80'(flush_done), 80'(0));
  endtask
  initial begin
    #12;
    chk_idle_empty("rst_hold");
    reset_n = 1'b1;
    step();
    chk_idle_empty("rst_rel");
    repeat (3) step();
    chk_idle_empty("rst_idle");
    out_ready = 1'b1;
    push(6, 1);
    chk("pk_fill6", 80'(fill_level), 80'(6));
    chk("pk_nv", 80'(out_valid), 80'(0));
    push(6, 7);
    chk("pk_valid", 80'(out_valid), 80'(1));
    chk("pk_cnt", 80'(out_count), 80'(8));
    chk("pk_data", data_out, w(1, 8));
    step();
    chk("pk_fill4", 80'(fill_level), 80'(4));
    chk("pk_nv2", 80'(out_valid), 80'(0));
    for (int i = 0; i < 4; i++) chk($sformatf("pk_acc%0d", i), 80'(dut.acc[i]), 80'(9 + i));
    do_reset();
    out_ready = 1'b0;
    push(6, 1);
    push(6, 7);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_fill_c%0d", c), 80'(fill_level), 80'(12));
      chk($sformatf("bp_rdy_c%0d", c), 80'(in_ready), 80'(0));
      chk($sformatf("bp_valid_c%0d", c), 80'(out_valid), 80'(1));
      chk($sformatf("bp_data_c%0d", c), data_out, w(1, 8));
      if (c < 4) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_pop_fill", 80'(fill_level), 80'(4));
    chk("bp_pop_rdy", 80'(in_ready), 80'(1));
    step();
    chk("bp_hold_fill", 80'(fill_level), 80'(4));
    do_reset();
    push(6, 1);
    push(2, 7);
    chk("pp_fill8", 80'(fill_level), 80'(8));
    chk("pp_data", data_out, w(1, 8));
    out_ready = 1'b1;
    push(3, 10);
    out_ready = 1'b0;
    chk("pp_fill3", 80'(fill_level), 80'(3));
    chk("pp_nv", 80'(out_valid), 80'(0));
    for (int i = 0; i < 3; i++) chk($sformatf("pp_acc%0d", i), 80'(dut.acc[i]), 80'(10 + i));
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("pf_rdy", 80'(in_ready), 80'(0));
    chk("pf_valid", 80'(out_valid), 80'(1));
    chk("pf_cnt", 80'(out_count), 80'(3));
    chk("pf_data", data_out, w(10, 3));
    chk("pf_nodone", 80'(flush_done), 80'(0));
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("pf_ignored_req", 80'(out_count), 80'(3));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pf_done", 80'(flush_done), 80'(1));
    chk("pf_fill0", 80'(fill_level), 80'(0));
    chk("pf_done_rdy", 80'(in_ready), 80'(0));
    step();
    chk("pf_done_gone", 80'(flush_done), 80'(0));
    chk("pf_rdy_back", 80'(in_ready), 80'(1));
    push(6, 1);
    push(6, 7);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("mf_cnt8", 80'(out_count), 80'(8));
    chk("mf_data8", data_out, w(1, 8));
    out_ready = 1'b1;
    step();
    chk("mf_cnt4", 80'(out_count), 80'(4));
    chk("mf_data4", data_out, w(9, 4));
    chk("mf_nodone", 80'(flush_done), 80'(0));
    step();
    out_ready = 1'b0;
    chk("mf_done", 80'(flush_done), 80'(1));
    step();
    out_ready = 1'b0;
    push(6, 1);
    push(6, 7);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mr_first_beat", 80'(out_count), 80'(4));
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_empty("mr_async");
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mr_nodone_c%0d", c), 80'(flush_done), 80'(0));
      chk($sformatf("mr_fill_c%0d", c), 80'(fill_level), 80'(0));
    end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("ef_c1", 80'(flush_done), 80'(0));
    chk("ef_rdy", 80'(in_ready), 80'(0));
    step();
    chk("ef_c2", 80'(flush_done), 80'(1));
    step();
    chk("ef_c3", 80'(flush_done), 80'(0));
    chk("ef_rdy_back", 80'(in_ready), 80'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
